// File: rtl/eth_pkg.sv
// ============================================================================
// Module  : eth_pkg
// Brief   : Shared ARP constants, state encoding and reply-byte helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package eth_pkg;

    localparam logic [15:0] ARP_ETHERTYPE  = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
    localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
    localparam logic [15:0] ARP_OPER_REP   = 16'd2;
    localparam int          ARP_BODY_LEN   = 28;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RX    = 3'd1,
        ST_CHECK = 3'd2,
        ST_REQ   = 3'd3,
        ST_TX    = 3'd4,
        ST_DROP  = 3'd5
    } arp_state_e;

    // Byte idx of an ARP reply body; indices past the body read as zero padding.
    function automatic logic [7:0] arp_reply_byte(
        input logic [7:0]  idx,
        input logic [47:0] sha,
        input logic [31:0] spa,
        input logic [47:0] tha,
        input logic [31:0] tpa
    );
        logic [223:0] body;
        body = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN_ETH, ARP_PLEN_IPV4,
                ARP_OPER_REP, sha, spa, tha, tpa};
        body = body << {idx, 3'b000};
        return body[223:216];
    endfunction

endpackage

`default_nettype wire

// File: rtl/arp_over_ethernet_if.sv
// ============================================================================
// Module  : arp_over_ethernet_if
// Brief   : Receive byte stream, transmit arbiter handshake and reply stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface arp_over_ethernet_if;
    logic        rx_dven;
    logic [7:0]  rx_data;
    logic        rx_err;
    logic        tx_grant;
    logic        tx_request;
    logic [47:0] tx_dmac;
    logic [15:0] tx_ethertype;
    logic        tx_dven;
    logic [7:0]  tx_data;
    logic        tx_busy;

    modport slave (
        input  rx_dven, rx_data, rx_err, tx_grant,
        output tx_request, tx_dmac, tx_ethertype, tx_dven, tx_data, tx_busy
    );

    modport master (
        output rx_dven, rx_data, rx_err, tx_grant,
        input  tx_request, tx_dmac, tx_ethertype, tx_dven, tx_data, tx_busy
    );
endinterface

`default_nettype wire

// File: rtl/arp_over_ethernet_rx_parser.sv
// ============================================================================
// Module  : arp_rx_parser
// Brief   : Captures ARP body fields by byte index and flags a well-formed frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module arp_rx_parser
    import eth_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start_i,
    input  wire logic        capture_i,
    input  wire logic        err_sample_i,
    input  wire logic [7:0]  rx_data_i,
    input  wire logic        rx_err_i,
    input  wire logic [31:0] ip_i,
    output logic             fields_ok_o,
    output logic [15:0]      oper_o,
    output logic [47:0]      sha_o,
    output logic [31:0]      spa_o
);

    logic [4:0]  count_q;
    logic        err_q;
    logic [15:0] htype_q;
    logic [15:0] ptype_q;
    logic [7:0]  hlen_q;
    logic [7:0]  plen_q;
    logic [15:0] oper_q;
    logic [47:0] sha_q;
    logic [31:0] spa_q;
    logic [31:0] tpa_q;

    logic [4:0]  byte_idx;
    logic        byte_we;

    // The first byte arrives with start_i, before the counter has been cleared.
    assign byte_idx = start_i ? 5'd0 : count_q;
    assign byte_we  = start_i | (capture_i & (count_q < 5'(ARP_BODY_LEN)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
            htype_q <= '0;
            ptype_q <= '0;
            hlen_q  <= '0;
            plen_q  <= '0;
            oper_q  <= '0;
            sha_q   <= '0;
            spa_q   <= '0;
            tpa_q   <= '0;
        end else begin
            if (err_sample_i) begin
                err_q <= rx_err_i;
            end
            if (byte_we) begin
                count_q <= byte_idx + 5'd1;
                if (byte_idx < 5'd2)       htype_q <= {htype_q[7:0], rx_data_i};
                else if (byte_idx < 5'd4)  ptype_q <= {ptype_q[7:0], rx_data_i};
                else if (byte_idx == 5'd4) hlen_q  <= rx_data_i;
                else if (byte_idx == 5'd5) plen_q  <= rx_data_i;
                else if (byte_idx < 5'd8)  oper_q  <= {oper_q[7:0], rx_data_i};
                else if (byte_idx < 5'd14) sha_q   <= {sha_q[39:0], rx_data_i};
                else if (byte_idx < 5'd18) spa_q   <= {spa_q[23:0], rx_data_i};
                else if (byte_idx >= 5'd24) tpa_q  <= {tpa_q[23:0], rx_data_i};
            end
        end
    end

    assign fields_ok_o = (count_q == 5'(ARP_BODY_LEN)) && !err_q
                      && (htype_q == ARP_HTYPE_ETH) && (ptype_q == ARP_PTYPE_IPV4)
                      && (hlen_q == ARP_HLEN_ETH) && (plen_q == ARP_PLEN_IPV4)
                      && (tpa_q == ip_i);
    assign oper_o = oper_q;
    assign sha_o  = sha_q;
    assign spa_o  = spa_q;

endmodule

`default_nettype wire

// File: rtl/arp_over_ethernet.sv
// ============================================================================
// Module  : arp_over_ethernet
// Brief   : ARP responder; ARP_CACHE_EN adds a one-entry cache of the last peer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module arp_over_ethernet #(
    parameter int          PADLEN        = 18,
    parameter logic [15:0] ARP_ETHERTYPE = 16'h0806
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [47:0] mac,
    input  wire logic [31:0] ip,
`ifdef ARP_CACHE_EN
    output logic             cache_valid,
    output logic [31:0]      cache_ip,
    output logic [47:0]      cache_mac,
`endif
    arp_over_ethernet_if.slave bus
);
    import eth_pkg::*;

    localparam logic [7:0] FRAME_LEN = 8'(ARP_BODY_LEN + PADLEN);

    arp_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        dven_q, dven_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  idx_q, idx_d;
    logic [47:0] dmac_q, dmac_d;
    logic [31:0] rtpa_q, rtpa_d;
    logic [47:0] smac_q, smac_d;
    logic [31:0] sip_q, sip_d;
    logic        rx_prev_q;

    logic        start, capture, err_sample;
    logic        fields_ok;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [7:0]  reply_byte;

`ifdef ARP_CACHE_EN
    logic        cval_q, cval_d;
    logic [31:0] cip_q, cip_d;
    logic [47:0] cmac_q, cmac_d;
`endif

    arp_rx_parser u_parser (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .capture_i    (capture),
        .err_sample_i (err_sample),
        .rx_data_i    (bus.rx_data),
        .rx_err_i     (bus.rx_err),
        .ip_i         (ip),
        .fields_ok_o  (fields_ok),
        .oper_o       (oper),
        .sha_o        (sha),
        .spa_o        (spa)
    );

    // The requester's MAC doubles as the reply's target hardware address.
    assign reply_byte = arp_reply_byte(idx_q, smac_q, sip_q, dmac_q, rtpa_q);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        dven_d     = 1'b0;
        data_d     = 8'h00;
        idx_d      = idx_q;
        dmac_d     = dmac_q;
        rtpa_d     = rtpa_q;
        smac_d     = smac_q;
        sip_d      = sip_q;
        start      = 1'b0;
        capture    = 1'b0;
        err_sample = 1'b0;
`ifdef ARP_CACHE_EN
        cval_d     = cval_q;
        cip_d      = cip_q;
        cmac_d     = cmac_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // A burst already in flight (seen after a reply) is skipped whole.
                if (bus.rx_dven) begin
                    if (!rx_prev_q) begin
                        start   = 1'b1;
                        state_d = ST_RX;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_RX: begin
                if (bus.rx_dven) begin
                    capture = 1'b1;
                end else begin
                    err_sample = 1'b1;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (fields_ok && (oper == ARP_OPER_REQ)) begin
                    dmac_d  = sha;
                    rtpa_d  = spa;
                    smac_d  = mac;
                    sip_d   = ip;
                    req_d   = 1'b1;
                    idx_d   = 8'd0;
                    state_d = ST_REQ;
                end
`ifdef ARP_CACHE_EN
                if (fields_ok && ((oper == ARP_OPER_REQ) || (oper == ARP_OPER_REP))) begin
                    cval_d = 1'b1;
                    cip_d  = spa;
                    cmac_d = sha;
                end
`endif
            end
            ST_REQ: begin
                if (bus.tx_grant) begin
                    req_d   = 1'b0;
                    dven_d  = 1'b1;
                    data_d  = reply_byte;
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (idx_q == FRAME_LEN) begin
                    state_d = ST_IDLE;
                end else begin
                    dven_d = 1'b1;
                    data_d = reply_byte;
                    idx_d  = idx_q + 8'd1;
                end
            end
            ST_DROP: begin
                if (!bus.rx_dven) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            dven_q    <= 1'b0;
            data_q    <= 8'h00;
            idx_q     <= 8'd0;
            dmac_q    <= '0;
            rtpa_q    <= '0;
            smac_q    <= '0;
            sip_q     <= '0;
            rx_prev_q <= 1'b0;
`ifdef ARP_CACHE_EN
            cval_q    <= 1'b0;
            cip_q     <= '0;
            cmac_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            dven_q    <= dven_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            dmac_q    <= dmac_d;
            rtpa_q    <= rtpa_d;
            smac_q    <= smac_d;
            sip_q     <= sip_d;
            rx_prev_q <= bus.rx_dven;
`ifdef ARP_CACHE_EN
            cval_q    <= cval_d;
            cip_q     <= cip_d;
            cmac_q    <= cmac_d;
`endif
        end
    end

    assign bus.tx_request   = req_q;
    assign bus.tx_dmac      = dmac_q;
    assign bus.tx_ethertype = ARP_ETHERTYPE;
    assign bus.tx_dven      = dven_q;
    assign bus.tx_data      = data_q;
    assign bus.tx_busy      = (state_q == ST_REQ) || (state_q == ST_TX);

`ifdef ARP_CACHE_EN
    assign cache_valid = cval_q;
    assign cache_ip    = cip_q;
    assign cache_mac   = cmac_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arp_over_ethernet.sv
// ============================================================================
// Module  : tb_arp_over_ethernet
// Brief   : Scoreboard bench for arp_over_ethernet (ARP_CACHE_EN aware).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arp_over_ethernet;

    localparam int PADLEN    = 18;
    localparam int FRAME_LEN = 28 + PADLEN;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] mac;
    logic [31:0] ip;
`ifdef ARP_CACHE_EN
    logic        cache_valid;
    logic [31:0] cache_ip;
    logic [47:0] cache_mac;
    logic        exp_cval = 1'b0;
    logic [31:0] exp_cip  = '0;
    logic [47:0] exp_cmac = '0;
`endif

    arp_over_ethernet_if bus ();

    arp_over_ethernet #(
        .PADLEN        (PADLEN),
        .ARP_ETHERTYPE (16'h0806)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mac         (mac),
        .ip          (ip),
`ifdef ARP_CACHE_EN
        .cache_valid (cache_valid),
        .cache_ip    (cache_ip),
        .cache_mac   (cache_mac),
`endif
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_bytes[$];
    logic [47:0] exp_dmac[$];
    logic [7:0]  frame[$];
    logic        prev_dven = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every reply byte is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (!reset) begin
            prev_dven = 1'b0;
        end else begin
            if (bus.tx_dven) begin
                if (!prev_dven) begin
                    if (exp_dmac.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_reply actual_dmac=%0h required=none", bus.tx_dmac);
                    end else begin
                        check("tx_dmac", bus.tx_dmac, exp_dmac.pop_front());
                    end
                    check("tx_ethertype", bus.tx_ethertype, 64'h0806);
                end
                if (exp_bytes.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_extra_byte actual=%0h required=none", bus.tx_data);
                end else begin
                    check("tx_data", bus.tx_data, exp_bytes.pop_front());
                end
            end else begin
                check("tx_data_idle", bus.tx_data, 0);
            end
            prev_dven = bus.tx_dven;
        end
    end

    task automatic build_frame(input logic [15:0] htype, input logic [15:0] ptype,
                               input logic [7:0] hlen, input logic [7:0] plen,
                               input logic [15:0] oper, input logic [47:0] sha,
                               input logic [31:0] spa, input logic [47:0] tha,
                               input logic [31:0] tpa, input int extra, input bit rnd_pad);
        logic [223:0] body;
        body = {htype, ptype, hlen, plen, oper, sha, spa, tha, tpa};
        frame.delete();
        for (int i = 0; i < 28; i++) frame.push_back(8'(body >> (216 - 8 * i)));
        for (int i = 0; i < extra; i++) frame.push_back(rnd_pad ? 8'($urandom) : 8'h00);
    endtask

    function automatic bit model_valid(input logic [7:0] f[$], input bit err, input logic [15:0] op);
        if (f.size() < 28 || err) return 1'b0;
        return ({f[0], f[1]} == 16'h0001) && ({f[2], f[3]} == 16'h0800)
            && (f[4] == 8'd6) && (f[5] == 8'd4) && ({f[6], f[7]} == op)
            && ({f[24], f[25], f[26], f[27]} == ip);
    endfunction

    task automatic push_reply(input logic [7:0] f[$]);
        logic [7:0] r[$];
        r = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
        for (int i = 0; i < 6; i++)  r.push_back(8'(mac >> (40 - 8 * i)));
        for (int i = 0; i < 4; i++)  r.push_back(8'(ip >> (24 - 8 * i)));
        for (int i = 8; i < 18; i++) r.push_back(f[i]);
        for (int i = 0; i < PADLEN; i++) r.push_back(8'h00);
        foreach (r[i]) exp_bytes.push_back(r[i]);
        exp_dmac.push_back({f[8], f[9], f[10], f[11], f[12], f[13]});
    endtask

    task automatic send_frame(input int len, input bit err);
        for (int i = 0; i < len; i++) begin
            bus.rx_dven = 1'b1;
            bus.rx_data = frame[i];
            @(posedge clk); #1;
        end
        bus.rx_dven = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_err  = err;
        @(posedge clk); #1;
        bus.rx_err  = 1'b0;
    endtask

    // Sends frame[0:len-1]; checks the request appears exactly two cycles after the fall.
    task automatic start_frame(input int len, input bit err, output bit acc);
        logic [7:0] sent[$];
        sent = frame[0:len-1];
        acc  = model_valid(sent, err, 16'h0001);
`ifdef ARP_CACHE_EN
        if (acc || model_valid(sent, err, 16'h0002)) begin
            exp_cval = 1'b1;
            exp_cip  = {sent[14], sent[15], sent[16], sent[17]};
            exp_cmac = {sent[8], sent[9], sent[10], sent[11], sent[12], sent[13]};
        end
`endif
        if (acc) push_reply(sent);
        send_frame(len, err);
        check("tx_request_before", bus.tx_request, 0);
        @(posedge clk); #1;
        check("tx_request_latency", bus.tx_request, 64'(acc));
        if (!acc) check("tx_busy_dropped", bus.tx_busy, 0);
`ifdef ARP_CACHE_EN
        check("cache_valid", cache_valid, 64'(exp_cval));
        check("cache_ip", cache_ip, 64'(exp_cip));
        check("cache_mac", cache_mac, 64'(exp_cmac));
`endif
    endtask

    task automatic finish_reply(input int gdelay);
        int n;
        repeat (gdelay) begin @(posedge clk); #1; end
        check("tx_request_hold", bus.tx_request, 1);
        bus.tx_grant = 1'b1;
        @(posedge clk); #1;
        bus.tx_grant = 1'b0;
        check("tx_request_after_grant", bus.tx_request, 0);
        check("tx_dven_after_grant", bus.tx_dven, 1);
        n = 0;
        while (bus.tx_busy && n < 200) begin @(posedge clk); #1; n++; end
        if (bus.tx_busy) begin
            checks++;
            failures++;
            $display("FAIL reply_timeout actual=busy required=idle");
        end
        check("reply_len", n, FRAME_LEN);
        check("reply_bytes_left", exp_bytes.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int len, kind;
        logic [15:0] htype, ptype, oper;
        logic [7:0]  hlen, plen;
        logic [31:0] tpa;

        reset = 1'b0;
        mac   = 48'h00105ad155b2;
        ip    = 32'hc0a801e0;
        bus.rx_dven = 1'b0; bus.rx_data = 8'h00; bus.rx_err = 1'b0; bus.tx_grant = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_request", bus.tx_request, 0);
        check("rst_tx_dven", bus.tx_dven, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_tx_dmac", bus.tx_dmac, 0);
        check("rst_tx_busy", bus.tx_busy, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed request for the local IP.
        build_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'hc46e1f01d90d,
                    32'hc0a801c8, 48'h0, 32'hc0a801e0, 18, 1'b0);
        start_frame(46, 1'b0, acc);
        check("directed_dmac", bus.tx_dmac, 48'hc46e1f01d90d);
        finish_reply(3);

        // Wrong target IP, FCS error, truncated frame.
        build_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'hc46e1f01d90d,
                    32'hc0a801c8, 48'h0, 32'hc0a801e1, 18, 1'b0);
        start_frame(46, 1'b0, acc);
        build_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'hc46e1f01d90d,
                    32'hc0a801c8, 48'h0, 32'hc0a801e0, 18, 1'b0);
        start_frame(46, 1'b1, acc);
        start_frame(20, 1'b0, acc);

        // Second request while the grant is withheld yields a single reply.
        start_frame(46, 1'b0, acc);
        build_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'h112233445566,
                    32'hc0a80177, 48'h0, 32'hc0a801e0, 18, 1'b0);
        send_frame(46, 1'b0);
        finish_reply(150);
        repeat (5) @(posedge clk);
        #1;
        check("single_reply_request", bus.tx_request, 0);

        // Reset in the middle of the reply.
        build_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001, 48'hc46e1f01d90d,
                    32'hc0a801c8, 48'h0, 32'hc0a801e0, 18, 1'b0);
        start_frame(46, 1'b0, acc);
        bus.tx_grant = 1'b1;
        @(posedge clk); #1;
        bus.tx_grant = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("pre_reset_dven", bus.tx_dven, 1);
        reset = 1'b0;
        #1;
        check("mid_reset_dven", bus.tx_dven, 0);
        check("mid_reset_data", bus.tx_data, 0);
        check("mid_reset_busy", bus.tx_busy, 0);
        check("mid_reset_dmac", bus.tx_dmac, 0);
        exp_bytes.delete();
        exp_dmac.delete();
`ifdef ARP_CACHE_EN
        exp_cval = 1'b0; exp_cip = '0; exp_cmac = '0;
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        start_frame(46, 1'b0, acc);
        finish_reply(0);

`ifdef ARP_CACHE_EN
        build_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0002, 48'haabbccddeeff,
                    32'hc0a80105, 48'h00105ad155b2, 32'hc0a801e0, 18, 1'b0);
        start_frame(46, 1'b0, acc);
        check("cache_reply_ip", cache_ip, 64'hc0a80105);
        check("cache_reply_mac", cache_mac, 64'haabbccddeeff);
`endif

        // Randomized frames, back-to-back where dropped.
        for (int it = 0; it < 40; it++) begin
            mac   = {16'($urandom), $urandom};
            ip    = $urandom;
            htype = 16'h0001; ptype = 16'h0800; hlen = 8'd6; plen = 8'd4;
            oper  = 16'h0001; tpa = ip;
            kind  = int'($urandom_range(0, 7));
            len   = 28 + int'($urandom_range(0, 20));
            if (kind == 3) begin
                case ($urandom_range(0, 4))
                    0: htype ^= 16'(1 << $urandom_range(0, 15));
                    1: ptype ^= 16'(1 << $urandom_range(0, 15));
                    2: hlen  ^= 8'(1 << $urandom_range(0, 7));
                    3: plen  ^= 8'(1 << $urandom_range(0, 7));
                    default: tpa ^= 32'(1 << $urandom_range(0, 31));
                endcase
            end
            if (kind == 6) oper = 16'h0002;
            if (kind == 7) oper = 16'($urandom_range(3, 65535));
            build_frame(htype, ptype, hlen, plen, oper, {16'($urandom), $urandom},
                        $urandom, {16'($urandom), $urandom}, tpa, len - 28, 1'b1);
            if (kind == 5) len = int'($urandom_range(1, 27));
            start_frame(len, kind == 4, acc);
            if (acc) finish_reply(int'($urandom_range(0, 5)));
        end

        repeat (5) @(posedge clk);
        #1;
        check("final_bytes_left", exp_bytes.size(), 0);
        check("final_dmac_left", exp_dmac.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
